// File: rtl/jtdsp16_sio_rx_if.sv
// Serial output bus of the DSP16 (sdo/ock/old/sadd).
// The DSP16 side drives it as master; the host receiver listens as slave.
interface jtdsp16_sio_rx_if;
  logic ock;
  logic old;
  logic sdo;
  logic sadd;

  modport master (output ock, output old, output sdo, output sadd);
  modport slave  (input  ock, input  old, input  sdo, input  sadd);
endinterface

// File: rtl/jtdsp16_sio_rx.sv
// Host-side receiver for the DSP16 serial output port.
// Deserialises words into left/right samples and flags framing errors.
//
// state | meaning
// IDLE  | waiting for an ock edge with old=1 (word start)
// SHIFT | collecting bits, cnt counts bits received so far
// DONE  | word complete; write it to left/right on the next cen cycle
module jtdsp16_sio_rx #(
  parameter int MSB_FIRST = 0,
  parameter int WORDLEN   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  jtdsp16_sio_rx_if.slave   sio,
  input  logic              clr_err,
  output logic [15:0]       left,
  output logic [15:0]       right,
  output logic              sample,
  output logic              busy,
  output logic              frame_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [4:0] LAST = 5'(WORDLEN);

  state_t      state;
  logic [1:0]  ock_s, old_s, sdo_s, sadd_s;
  logic        ock_d;
  logic [4:0]  cnt;
  logic [15:0] shreg;
  logic [15:0] first_sh, next_sh, word;
  logic        ch;
  logic        edge_hit;

  assign edge_hit = ock_s[1] & ~ock_d;
  assign busy     = (state == SHIFT);

  always_comb begin
    first_sh = 16'd0;
    next_sh  = 16'd0;
    if (MSB_FIRST != 0) begin
      first_sh = {15'd0, sdo_s[1]};
      next_sh  = {shreg[14:0], sdo_s[1]};
    end else begin
      first_sh = {sdo_s[1], 15'd0};
      next_sh  = {sdo_s[1], shreg[15:1]};
    end
  end

  // LSB-first short words land in the top byte of shreg and must be moved down
  always_comb begin
    word = shreg;
    if (WORDLEN == 8) begin
      if (MSB_FIRST != 0) word = {8'd0, shreg[7:0]};
      else                word = {8'd0, shreg[15:8]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ock_s     <= 2'b00;
      old_s     <= 2'b00;
      sdo_s     <= 2'b00;
      sadd_s    <= 2'b00;
      ock_d     <= 1'b0;
      cnt       <= 5'd0;
      shreg     <= 16'd0;
      ch        <= 1'b0;
      left      <= 16'd0;
      right     <= 16'd0;
      sample    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sample <= 1'b0;
      if (cen) begin
        ock_s  <= {ock_s[0],  sio.ock};
        old_s  <= {old_s[0],  sio.old};
        sdo_s  <= {sdo_s[0],  sio.sdo};
        sadd_s <= {sadd_s[0], sio.sadd};
        ock_d  <= ock_s[1];
        if (clr_err) frame_err <= 1'b0;
        case (state)
          IDLE: begin
            if (edge_hit && old_s[1]) begin
              shreg <= first_sh;
              ch    <= sadd_s[1];
              cnt   <= 5'd1;
              state <= SHIFT;
            end
          end
          SHIFT: begin
            if (edge_hit) begin
              if (old_s[1] && cnt < LAST) begin
                frame_err <= 1'b1;
                shreg     <= first_sh;
                ch        <= sadd_s[1];
                cnt       <= 5'd1;
              end else begin
                shreg <= next_sh;
                cnt   <= (cnt < LAST) ? cnt + 5'd1 : cnt;
                if (cnt + 5'd1 >= LAST) state <= DONE;
              end
            end
          end
          DONE: begin
            if (ch) begin
              right  <= word;
              sample <= 1'b1;
            end else begin
              left <= word;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtdsp16_sio_rx.sv
// Directed bench for jtdsp16_sio_rx: LSB-first 16-bit receiver plus an MSB-first 8-bit one.
module tb_jtdsp16_sio_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] left0, right0, left1, right1;
  logic        sample0, busy0, frame_err0;
  logic        sample1, busy1, frame_err1;

  int checks = 0;
  int errors = 0;
  int sample_cnt = 0;
  int run_len = 0;
  int max_run = 0;

  jtdsp16_sio_rx_if bus0 ();
  jtdsp16_sio_rx_if bus1 ();

  jtdsp16_sio_rx #(.MSB_FIRST(0), .WORDLEN(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .sio(bus0.slave), .clr_err(clr_err),
    .left(left0), .right(right0), .sample(sample0), .busy(busy0), .frame_err(frame_err0)
  );

  jtdsp16_sio_rx #(.MSB_FIRST(1), .WORDLEN(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .sio(bus1.slave), .clr_err(clr_err),
    .left(left1), .right(right1), .sample(sample1), .busy(busy1), .frame_err(frame_err1)
  );

  always #5 clk = ~clk;
  always @(negedge clk) cen = ~cen;

  // count sample pulses of dut0 and track the longest high run in clk cycles
  always @(negedge clk) begin
    if (sample0) begin
      run_len = run_len + 1;
      if (run_len == 1) sample_cnt = sample_cnt + 1;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  task automatic drive(input bit sel, input logic ock_v, input logic old_v,
                       input logic sdo_v, input logic sadd_v);
    if (sel) begin
      bus1.ock = ock_v; bus1.old = old_v; bus1.sdo = sdo_v; bus1.sadd = sadd_v;
    end else begin
      bus0.ock = ock_v; bus0.old = old_v; bus0.sdo = sdo_v; bus0.sadd = sadd_v;
    end
  endtask

  // sends nbits of data; old is high for bit 0 only
  task automatic send_bits(input bit sel, input logic [15:0] data, input logic tag,
                           input int nbits, input bit msb);
    int idx;
    for (int i = 0; i < nbits; i++) begin
      idx = msb ? (nbits - 1 - i) : i;
      drive(sel, 1'b0, (i == 0), data[idx], tag);
      #100;
      drive(sel, 1'b1, (i == 0), data[idx], tag);
      #100;
    end
    drive(sel, 1'b0, 1'b0, 1'b0, tag);
    #300;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #45;
    checks++; if (left0 !== 16'h0)    begin errors++; $display("FAIL reset_left got %h want 0000", left0); end
    checks++; if (right0 !== 16'h0)   begin errors++; $display("FAIL reset_right got %h want 0000", right0); end
    checks++; if (sample0 !== 1'b0)   begin errors++; $display("FAIL reset_sample got %b want 0", sample0); end
    checks++; if (busy0 !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy0); end
    checks++; if (frame_err0 !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err0); end
    @(negedge clk);
    rst_n = 1'b1;
    #100;
  endtask

  task automatic test_left_word;
    int s0;
    s0 = sample_cnt;
    fork
      send_bits(1'b0, 16'h1234, 1'b0, 16, 1'b0);
      begin
        #1500;
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL busy_mid_word got %b want 1", busy0); end
      end
    join
    checks++; if (left0 !== 16'h1234)  begin errors++; $display("FAIL left_word got %h want 1234", left0); end
    checks++; if (right0 !== 16'h0000) begin errors++; $display("FAIL left_word_right got %h want 0000", right0); end
    checks++; if (sample_cnt !== s0)   begin errors++; $display("FAIL left_word_sample got %0d pulses want 0", sample_cnt - s0); end
    checks++; if (busy0 !== 1'b0)      begin errors++; $display("FAIL busy_after_word got %b want 0", busy0); end
  endtask

  task automatic test_same_channel;
    int s0;
    s0 = sample_cnt;
    send_bits(1'b0, 16'h00FF, 1'b0, 16, 1'b0);
    send_bits(1'b0, 16'hABCD, 1'b0, 16, 1'b0);
    checks++; if (left0 !== 16'hABCD) begin errors++; $display("FAIL overwrite_left got %h want abcd", left0); end
    checks++; if (sample_cnt !== s0)  begin errors++; $display("FAIL overwrite_sample got %0d pulses want 0", sample_cnt - s0); end
  endtask

  task automatic test_stereo;
    int s0;
    s0 = sample_cnt;
    max_run = 0;
    send_bits(1'b0, 16'h8001, 1'b0, 16, 1'b0);
    send_bits(1'b0, 16'h7FFE, 1'b1, 16, 1'b0);
    checks++; if (left0 !== 16'h8001)     begin errors++; $display("FAIL stereo_left got %h want 8001", left0); end
    checks++; if (right0 !== 16'h7FFE)    begin errors++; $display("FAIL stereo_right got %h want 7ffe", right0); end
    checks++; if (sample_cnt !== s0 + 1)  begin errors++; $display("FAIL stereo_sample_count got %0d want 1", sample_cnt - s0); end
    checks++; if (max_run !== 1)          begin errors++; $display("FAIL stereo_sample_width got %0d want 1", max_run); end
    checks++; if (frame_err0 !== 1'b0)    begin errors++; $display("FAIL stereo_frame_err got %b want 0", frame_err0); end
  endtask

  task automatic test_early_restart;
    int s0;
    s0 = sample_cnt;
    send_bits(1'b0, 16'hFFFF, 1'b0, 9, 1'b0);
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL partial_busy got %b want 1", busy0); end
    send_bits(1'b0, 16'hA5A5, 1'b1, 16, 1'b0);
    checks++; if (frame_err0 !== 1'b1)   begin errors++; $display("FAIL restart_frame_err got %b want 1", frame_err0); end
    checks++; if (right0 !== 16'hA5A5)   begin errors++; $display("FAIL restart_right got %h want a5a5", right0); end
    checks++; if (left0 !== 16'h8001)    begin errors++; $display("FAIL restart_left got %h want 8001", left0); end
    checks++; if (sample_cnt !== s0 + 1) begin errors++; $display("FAIL restart_sample got %0d want 1", sample_cnt - s0); end
  endtask

  task automatic test_msb8_clr_err;
    send_bits(1'b1, 16'h00C3, 1'b0, 8, 1'b1);
    checks++; if (left1 !== 16'h00C3)  begin errors++; $display("FAIL msb8_left got %h want 00c3", left1); end
    checks++; if (frame_err1 !== 1'b0) begin errors++; $display("FAIL msb8_frame_err got %b want 0", frame_err1); end
    checks++; if (frame_err0 !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", frame_err0); end
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr_err = 1'b0;
    #20;
    checks++; if (frame_err0 !== 1'b0) begin errors++; $display("FAIL clr_err got %b want 0", frame_err0); end
  endtask

  task automatic test_reset_mid_word;
    send_bits(1'b0, 16'h5555, 1'b0, 7, 1'b0);
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b want 1", busy0); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (busy0 !== 1'b0)     begin errors++; $display("FAIL mid_reset_busy got %b want 0", busy0); end
    checks++; if (left0 !== 16'h0)    begin errors++; $display("FAIL mid_reset_left got %h want 0000", left0); end
    checks++; if (right0 !== 16'h0)   begin errors++; $display("FAIL mid_reset_right got %h want 0000", right0); end
    #100;
    send_bits(1'b0, 16'h0F0F, 1'b0, 16, 1'b0);
    checks++; if (left0 !== 16'h0F0F)  begin errors++; $display("FAIL post_reset_left got %h want 0f0f", left0); end
    checks++; if (frame_err0 !== 1'b0) begin errors++; $display("FAIL post_reset_frame_err got %b want 0", frame_err0); end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_left_word();
    test_same_channel();
    test_stereo();
    test_early_restart();
    test_msb8_clr_err();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
